bcd_low_digits: RTL and testbench
=================================

# bcd_low_digits

Back-end stage of the binary-to-BCD pipeline. It sits directly downstream of the thousands stage and consumes that stage's registered outputs: the 10-bit remainder, the partial 17-bit BCD word and the valid bit. Three pipelined sub-stages extract the hundreds, tens and units digits. The final BCD word is held on the output with a valid strobe, a sticky range-error flag and a wrapping result counter.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low
- bin_vld_in  input  1  input word valid, one cycle per word; driven by the thousands stage `bin_vld_q`
- bin_in  input  10  remainder after thousands extraction; legal range 0..999
- bcd_in  input  17  partial BCD; bits 15:12 hold the thousands digit, all other bits 0
- bcd_out  output  17  final BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units, [16] copied from bcd_in[16]
- bcd_vld  output  1  one-cycle strobe; bcd_out updated this cycle
- range_err  output  1  sticky flag; an out-of-range bin_in was accepted
- res_cnt  output  16  count of results produced; wraps

## Operation
- No stall or back-pressure. All three stage registers advance on every clk edge.
- Valid travels alongside the data as v1→v2→v3. Data registers load unconditionally. Bubbles (valid = 0) flow through the pipeline and are ignored at the output.
- Stage H (hundreds), from bin_in and bcd_in:
  - h = largest k in 0..9 with 100·k ≤ bin_in.
  - rem1 = bin_in − 100·h, width 10 bits.
  - bcd1 = bcd_in | (h << 8).
  - Implement as a parallel compare against 900, 800, …, 100 (a priority select), not a divider.
- Stage T (tens):
  - t = largest k in 0..9 with 10·k ≤ rem1.
  - rem2 = rem1 − 10·t, 7 bits.
  - bcd2 = bcd1 | (t << 4).
- Stage U (units):
  - bcd3 = bcd2 | rem2[3:0].
- Output register:
  - When v3 = 1: bcd_out ← bcd3, bcd_vld ← 1, res_cnt ← res_cnt + 1 (0xFFFF wraps to 0x0000).
  - When v3 = 0: bcd_out holds its previous value and bcd_vld ← 0.
- Out-of-range input (bin_vld_in = 1 and bin_in ≥ 1000):
  - Stage H forces h = 9, rem1 = 99, so the result's lower digits become 999.
  - range_err sets on the same edge that Stage H captures the word.
  - range_err clears only on reset.
  - When bin_vld_in = 0, bin_in ≥ 1000 has no effect on the flag.
- Digit fields are ORed in, relying on bcd_in bits 11:0 being 0. The block does not mask them.

## Timing
- Latency: a word sampled with bin_vld_in = 1 at edge N appears on bcd_out, with bcd_vld = 1, after edge N+3.
- Throughput: one word per cycle. Back-to-back inputs produce back-to-back strobes in the same order.
- Reset (asynchronous, any time, including mid-pipeline):
  - All stage data and valid registers clear to 0.
  - bcd_out = 0, bcd_vld = 0, range_err = 0, res_cnt = 0.
  - Words in flight are discarded; no strobe is produced for them.
- After rst_n deasserts, the first word is accepted at the first rising edge with bin_vld_in = 1.
- range_err rises one cycle after the offending input is presented, three edges ahead of that word's output strobe.
- res_cnt and bcd_vld change on the same edge.

## Test plan
- Single words:
  - bcd_in = 0x00000 with bin_in = 0, then 999, then 505 → bcd_out 0x00000, 0x00999, 0x00505.
  - Each strobe appears exactly 3 edges after its input.
  - res_cnt ends at 3.
- Full-path values, driven as thousands-stage outputs:
  - bin_in = 23 with bcd_in = 0x01000 (i.e. 1023) → 0x01023.
  - bin_in = 0 with bcd_in = 0x01000 → 0x01000.
- Throughput and holding:
  - Back-to-back burst 100, 110, 9, 90 → four consecutive strobes 0x00100, 0x00110, 0x00009, 0x00090.
  - Then one bubble cycle: bcd_out holds 0x00090 with bcd_vld = 0.
- Range error:
  - bin_in = 1000 with bin_vld_in = 1 → range_err = 1 one cycle later; output 0x00999.
  - bin_in = 1023 with bin_vld_in = 0 → flag unaffected.
- Reset mid-pipeline:
  - Inject 3 words, assert rst_n low after 2 edges → all outputs 0 immediately; no strobe after release.
  - A new word 0x1 then yields 0x00001 with res_cnt = 1.
- Counter wrap: force 65536 valid outputs → res_cnt returns to 0x0000 on the 65536th strobe.

Source files
------------

// File: rtl/bcd_low_digits.sv
// Back-end of the binary-to-BCD pipeline: extracts hundreds, tens and units
// from the thousands-stage remainder in three registered sub-stages.
module bcd_low_digits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bin_vld_in,
    input  logic [9:0]  bin_in,
    input  logic [16:0] bcd_in,
    output logic [16:0] bcd_out,
    output logic        bcd_vld,
    output logic        range_err,
    output logic [15:0] res_cnt
);

    logic        v1, v2, v3;
    logic [9:0]  rem1_q;
    logic [3:0]  rem2_q;
    logic [16:0] bcd1_q, bcd2_q, bcd3_q;

    logic        oor;
    logic [3:0]  h_d, t_d;
    logic [9:0]  rem1_d;
    logic [3:0]  rem2_d;

    // Hundreds: priority select over parallel compares; out-of-range saturates to 999.
    always_comb begin
        oor    = (bin_in >= 10'd1000);
        h_d    = 4'd0;
        rem1_d = bin_in;
        for (int k = 1; k <= 9; k++) begin
            if (bin_in >= 10'(100 * k)) begin
                h_d    = 4'(k);
                rem1_d = bin_in - 10'(100 * k);
            end
        end
        if (oor) begin
            h_d    = 4'd9;
            rem1_d = 10'd99;
        end
    end

    // Tens: the leftover after the tens digit is always below 10, so 4 bits hold it.
    always_comb begin
        t_d    = 4'd0;
        rem2_d = rem1_q[3:0];
        for (int k = 1; k <= 9; k++) begin
            if (rem1_q >= 10'(10 * k)) begin
                t_d    = 4'(k);
                rem2_d = 4'(rem1_q - 10'(10 * k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            rem1_q    <= '0;
            rem2_q    <= '0;
            bcd1_q    <= '0;
            bcd2_q    <= '0;
            bcd3_q    <= '0;
            bcd_out   <= '0;
            bcd_vld   <= 1'b0;
            range_err <= 1'b0;
            res_cnt   <= '0;
        end else begin
            v1     <= bin_vld_in;
            rem1_q <= rem1_d;
            bcd1_q <= bcd_in | {5'b0, h_d, 8'b0};

            v2     <= v1;
            rem2_q <= rem2_d;
            bcd2_q <= bcd1_q | {9'b0, t_d, 4'b0};

            v3     <= v2;
            bcd3_q <= bcd2_q | {13'b0, rem2_q};

            bcd_vld <= v3;
            if (v3) begin
                bcd_out <= bcd3_q;
                res_cnt <= res_cnt + 16'd1;
            end

            if (bin_vld_in && oor)
                range_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_low_digits.sv
// Directed self-checking bench for bcd_low_digits: vector table plus
// hand-written burst, range-error, reset and counter-wrap sequences.
module tb_bcd_low_digits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bin_vld_in;
    logic [9:0]  bin_in;
    logic [16:0] bcd_in;
    logic [16:0] bcd_out;
    logic        bcd_vld;
    logic        range_err;
    logic [15:0] res_cnt;

    int tests = 0;
    int fails = 0;

    bcd_low_digits dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bin_vld_in (bin_vld_in),
        .bin_in     (bin_in),
        .bcd_in     (bcd_in),
        .bcd_out    (bcd_out),
        .bcd_vld    (bcd_vld),
        .range_err  (range_err),
        .res_cnt    (res_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  bin;
        logic [16:0] bcd;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [16:0] burst_exp[4];
    logic [9:0]  burst_in[4];
    int          strobes;
    int          exp_cnt;

    initial begin
        vecs[0] = '{10'd0,    17'h00000, 17'h00000};
        vecs[1] = '{10'd999,  17'h00000, 17'h00999};
        vecs[2] = '{10'd505,  17'h00000, 17'h00505};
        vecs[3] = '{10'd23,   17'h01000, 17'h01023};
        vecs[4] = '{10'd0,    17'h01000, 17'h01000};
        vecs[5] = '{10'd10,   17'h09000, 17'h09010};
        vecs[6] = '{10'd42,   17'h10000, 17'h10042};
        vecs[7] = '{10'd99,   17'h00000, 17'h00099};
        burst_in  = '{10'd100, 10'd110, 10'd9, 10'd90};
        burst_exp = '{17'h00100, 17'h00110, 17'h00009, 17'h00090};

        rst_n = 1'b0; bin_vld_in = 1'b0; bin_in = '0; bcd_in = '0;
        #12;
        chk("reset bcd_out", 32'(bcd_out), 32'h0);
        chk("reset bcd_vld", 32'(bcd_vld), 32'h0);
        chk("reset range_err", 32'(range_err), 32'h0);
        chk("reset res_cnt", 32'(res_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single words: strobe must be absent after N+2 and present after N+3.
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bin_vld_in = 1'b1; bin_in = vecs[i].bin; bcd_in = vecs[i].bcd;
            tick();
            bin_vld_in = 1'b0; bin_in = '0; bcd_in = '0;
            tick();
            tick();
            chk($sformatf("vec%0d early vld", i), 32'(bcd_vld), 32'h0);
            tick();
            exp_cnt++;
            chk($sformatf("vec%0d vld", i), 32'(bcd_vld), 32'h1);
            chk($sformatf("vec%0d bcd_out", i), 32'(bcd_out), 32'(vecs[i].exp));
            chk($sformatf("vec%0d res_cnt", i), 32'(res_cnt), 32'(exp_cnt));
            tick();
            chk($sformatf("vec%0d vld drop", i), 32'(bcd_vld), 32'h0);
        end

        // Back-to-back burst then one bubble.
        bin_vld_in = 1'b1; bin_in = burst_in[0]; bcd_in = '0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j + 1 < 4) bin_in = burst_in[j + 1];
            else begin bin_vld_in = 1'b0; bin_in = '0; end
            if (j >= 3 && j <= 6) begin
                chk($sformatf("burst%0d vld", j - 3), 32'(bcd_vld), 32'h1);
                chk($sformatf("burst%0d out", j - 3), 32'(bcd_out), 32'(burst_exp[j - 3]));
            end
            if (j == 7) begin
                chk("bubble vld", 32'(bcd_vld), 32'h0);
                chk("bubble hold", 32'(bcd_out), 32'h00090);
            end
        end
        exp_cnt += 4;
        chk("burst res_cnt", 32'(res_cnt), 32'(exp_cnt));

        // Out-of-range value with valid low must not set the flag or strobe.
        bin_vld_in = 1'b0; bin_in = 10'd1023;
        for (int j = 0; j < 4; j++) tick();
        chk("oor invalid flag", 32'(range_err), 32'h0);
        chk("oor invalid vld", 32'(bcd_vld), 32'h0);

        bin_vld_in = 1'b1; bin_in = 10'd1000; bcd_in = '0;
        chk("range_err pre", 32'(range_err), 32'h0);
        tick();
        bin_vld_in = 1'b0; bin_in = '0;
        chk("range_err set", 32'(range_err), 32'h1);
        tick(); tick(); tick();
        chk("oor vld", 32'(bcd_vld), 32'h1);
        chk("oor out", 32'(bcd_out), 32'h00999);
        tick();
        chk("range_err sticky", 32'(range_err), 32'h1);

        // Reset mid-pipeline.
        bin_vld_in = 1'b1; bin_in = 10'd1;
        tick();
        bin_in = 10'd2;
        tick();
        bin_in = 10'd3;
        rst_n = 1'b0;
        #1;
        chk("midrst bcd_out", 32'(bcd_out), 32'h0);
        chk("midrst range_err", 32'(range_err), 32'h0);
        chk("midrst res_cnt", 32'(res_cnt), 32'h0);
        chk("midrst vld", 32'(bcd_vld), 32'h0);
        bin_vld_in = 1'b0; bin_in = '0;
        #10;
        rst_n = 1'b1;
        strobes = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (bcd_vld) strobes++;
        end
        chk("midrst no strobe", 32'(strobes), 32'h0);
        bin_vld_in = 1'b1; bin_in = 10'd1;
        tick();
        bin_vld_in = 1'b0; bin_in = '0;
        tick(); tick(); tick();
        chk("post rst vld", 32'(bcd_vld), 32'h1);
        chk("post rst out", 32'(bcd_out), 32'h00001);
        chk("post rst res_cnt", 32'(res_cnt), 32'h1);

        // Counter wrap over 65536 consecutive results.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        bin_vld_in = 1'b1; bin_in = 10'd7;
        strobes = 0;
        for (int j = 0; j < 65546; j++) begin
            tick();
            if (j == 65535) bin_vld_in = 1'b0;
            if (bcd_vld) begin
                strobes++;
                if (strobes == 65535) chk("wrap pre", 32'(res_cnt), 32'hFFFF);
                if (strobes == 65536) chk("wrap zero", 32'(res_cnt), 32'h0);
            end
        end
        chk("wrap strobes", 32'(strobes), 32'd65536);
        chk("wrap out", 32'(bcd_out), 32'h00007);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
